btn_conditioner: RTL and testbench

Front-end input stage for the maze game: turns the five raw board push-buttons into synchronised, debounced levels, one-cycle press pulses and a clean one-hot direction with move strobes that auto-repeat. It sits directly upstream of the game top's movement logic, which consumes dir/move_stb in place of raw btn[4:1] and btn_db[0] as the position-reset request. It also generates the game tick, replacing the ad-hoc divider in the game top.

---
 rtl/btn_pkg.sv | 35 +++
 rtl/btn_debounce.sv | 50 +++++
 rtl/btn_conditioner.sv | 113 +++++++++++
 tb/tb_btn_conditioner.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the maze-game button front end: indices, one-hot directions,
// repeat FSM encoding and the direction decode helper.
package btn_pkg;

    localparam int unsigned NUM_BTN = 5;
    localparam int unsigned DIR_W   = 4;

    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_L = 2;
    localparam int unsigned BTN_R = 3;
    localparam int unsigned BTN_D = 4;

    localparam logic [DIR_W-1:0] DIR_U = 4'b0001;
    localparam logic [DIR_W-1:0] DIR_L = 4'b0010;
    localparam logic [DIR_W-1:0] DIR_R = 4'b0100;
    localparam logic [DIR_W-1:0] DIR_D = 4'b1000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Single direction button held and centre released, else no direction.
    function automatic logic [DIR_W-1:0] decode_dir(input logic [NUM_BTN-1:0] db);
        logic [DIR_W-1:0] d;
        d = db[DIR_W:1];
        if (db[BTN_C] || (d == 4'd0) || ((d & (d - 4'd1)) != 4'd0)) begin
            return 4'd0;
        end
        return d;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser followed by a hold-time debounce counter and a
// registered rising-edge pulse on the debounced level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Any sample matching the current level restarts the hold window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            db   <= 1'b0;
            rise <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt  <= '0;
                db   <= sync;
                rise <= sync;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Maze-game button front end: debounced levels, press pulses, one-hot direction with
// auto-repeating move strobes, and the free-running game tick.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES    = 1_000_000,
    parameter int unsigned CNT_W              = 20,
    parameter int unsigned TICK_DIV           = 400_000,
    parameter int unsigned REPEAT_DELAY_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_db,
    output logic [4:0] btn_rise,
    output logic [3:0] dir,
    output logic       move_stb,
    output logic       game_tick
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned RPT_W  = (REPEAT_DELAY_TICKS > 1) ? $clog2(REPEAT_DELAY_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_DELAY_TICKS - 1);

    logic [TICK_W-1:0] tick_cnt;
    logic [3:0]        dir_next;
    rpt_state_t        state;
    rpt_state_t        state_d;
    logic [3:0]        dir_d;
    logic [RPT_W-1:0]  rpt_cnt;
    logic [RPT_W-1:0]  rpt_cnt_d;
    logic              move_stb_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk (clk),
            .rst (rst),
            .raw (btn_raw[i]),
            .db  (btn_db[i]),
            .rise(btn_rise[i])
        );
    end

    // Free-running divider; the pulse marks the cycle the counter has wrapped to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt  <= '0;
            game_tick <= 1'b0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt  <= '0;
            game_tick <= 1'b1;
        end else begin
            tick_cnt  <= tick_cnt + TICK_W'(1);
            game_tick <= 1'b0;
        end
    end

    assign dir_next = decode_dir(btn_db);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            dir      <= '0;
            rpt_cnt  <= '0;
            move_stb <= 1'b0;
        end else begin
            state    <= state_d;
            dir      <= dir_d;
            rpt_cnt  <= rpt_cnt_d;
            move_stb <= move_stb_d;
        end
    end

    // Direction changes beat ticks; a new direction arriving right after a strobe is
    // held off one cycle so strobes never run back to back.
    always_comb begin
        state_d    = state;
        dir_d      = dir;
        rpt_cnt_d  = rpt_cnt;
        move_stb_d = 1'b0;
        if (dir_next != dir) begin
            if (dir_next == 4'd0) begin
                state_d   = IDLE;
                dir_d     = 4'd0;
                rpt_cnt_d = '0;
            end else if (!move_stb) begin
                state_d    = DELAY;
                dir_d      = dir_next;
                rpt_cnt_d  = '0;
                move_stb_d = 1'b1;
            end
        end else if (game_tick && !move_stb) begin
            case (state)
                DELAY: begin
                    if (rpt_cnt == RPT_LAST) begin
                        state_d    = REPEAT;
                        move_stb_d = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt + RPT_W'(1);
                    end
                end
                REPEAT:  move_stb_d = 1'b1;
                IDLE:    ;
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: stimulus queues expected strobes and press pulses,
// a negedge monitor pops and compares them whenever the DUT presents one.
module tb_btn_conditioner;
    import btn_pkg::*;

    localparam int DB = 4;
    localparam int TD = 5;
    localparam int RD = 2;

    typedef struct {
        int         cyc;
        logic [4:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] btn_raw = 5'd0;
    logic [4:0] btn_db;
    logic [4:0] btn_rise;
    logic [3:0] dir;
    logic       move_stb;
    logic       game_tick;

    int   cyc = 0;
    int   rel = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t stb_q[$];
    exp_t rise_q[$];

    btn_conditioner #(
        .DEBOUNCE_CYCLES   (DB),
        .CNT_W             (3),
        .TICK_DIV          (TD),
        .REPEAT_DELAY_TICKS(RD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_db   (btn_db),
        .btn_rise (btn_rise),
        .dir      (dir),
        .move_stb (move_stb),
        .game_tick(game_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_rise(input int c, input logic [4:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        rise_q.push_back(e);
    endtask

    // Strobe at s, then after RD ticks one per tick, until the released level reaches the FSM.
    task automatic hold_expect(input logic [3:0] d, input int s, input int k1);
        exp_t e;
        int   n;
        e.cyc = s;
        e.val = {1'b0, d};
        stb_q.push_back(e);
        n = 0;
        for (int t = s; t <= k1 + DB + 1; t++) begin
            if (t > rel && ((t - rel) % TD) == 0) begin
                n++;
                if (n >= RD) begin
                    e.cyc = t + 1;
                    stb_q.push_back(e);
                end
            end
        end
    endtask

    task automatic post(input int n);
        @(posedge clk);
        #1;
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_neg(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (move_stb === 1'b1) begin
            if (stb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL stb_unexpected: got dir %0h at cyc %0d, expected none", dir, cyc);
            end else begin
                e = stb_q.pop_front();
                chk("stb_cyc", cyc, e.cyc);
                chk("stb_dir", {28'd0, dir}, {28'd0, e.val[3:0]});
            end
        end
        if (btn_rise !== 5'd0) begin
            if (rise_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rise_unexpected: got %0h at cyc %0d, expected none", btn_rise, cyc);
            end else begin
                e = rise_q.pop_front();
                chk("rise_cyc", cyc, e.cyc);
                chk("rise_val", {27'd0, btn_rise}, {27'd0, e.val});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, j, k0, b, c, i;
        logic got;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_db", {27'd0, btn_db}, 0);
        chk("rst_rise", {27'd0, btn_rise}, 0);
        chk("rst_dir", {28'd0, dir}, 0);
        chk("rst_stb", {31'd0, move_stb}, 0);
        chk("rst_tick", {31'd0, game_tick}, 0);
        rst = 1'b1;
        rel = cyc;

        at_neg(rel + 4);
        chk("tick_before", {31'd0, game_tick}, 0);
        at_neg(rel + 5);
        chk("tick_first", {31'd0, game_tick}, 1);
        at_neg(rel + 6);
        chk("tick_after", {31'd0, game_tick}, 0);

        // Reset mid-operation while up is held
        k = rel + 7;
        post(k);
        btn_raw[BTN_U] = 1'b1;
        push_rise(k + 6, 5'b00010);
        hold_expect(DIR_U, k + 7, k + 100);
        stb_q = {stb_q[0]};
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (move_stb === 1'b1) got = 1'b1;
        end
        chk("wait_first_stb", {31'd0, got}, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_db", {27'd0, btn_db}, 0);
        chk("arst_rise", {27'd0, btn_rise}, 0);
        chk("arst_dir", {28'd0, dir}, 0);
        chk("arst_stb", {31'd0, move_stb}, 0);
        chk("arst_tick", {31'd0, game_tick}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rel = cyc;
        j = cyc;
        push_rise(j + 6, 5'b00010);
        hold_expect(DIR_U, j + 7, j + 8);
        at_neg(j + 5);
        chk("rel_db_early", {27'd0, btn_db}, 0);
        at_neg(j + 6);
        chk("rel_db_back", {27'd0, btn_db}, 32'b00010);
        post(j + 8);
        btn_raw[BTN_U] = 1'b0;

        // Clean step on right
        k0 = j + 20;
        post(k0);
        btn_raw[BTN_R] = 1'b1;
        push_rise(k0 + 6, 5'b01000);
        hold_expect(DIR_R, k0 + 7, k0 + 9);
        at_neg(k0 + 6);
        chk("clean_db", {27'd0, btn_db}, 32'b01000);
        at_neg(k0 + 7);
        chk("clean_dir", {28'd0, dir}, {28'd0, DIR_R});
        chk("clean_rise_off", {27'd0, btn_rise}, 0);
        post(k0 + 9);
        btn_raw[BTN_R] = 1'b0;

        // Bounce on left, then hold and switch to down on a tick edge, then auto-repeat
        b = k0 + 25;
        c = b + 20;
        while (((c + DB + 2 - rel) % TD) != 0) c++;
        push_rise(b + 10, 5'b00100);
        hold_expect(DIR_L, b + 11, c);
        push_rise(c + 6, 5'b10000);
        hold_expect(DIR_D, c + 7, c + 40);
        post(b);
        btn_raw[BTN_L] = 1'b1;
        post(b + 1);
        btn_raw[BTN_L] = 1'b0;
        post(b + 2);
        btn_raw[BTN_L] = 1'b1;
        post(b + 3);
        btn_raw[BTN_L] = 1'b0;
        post(b + 4);
        btn_raw[BTN_L] = 1'b1;
        at_neg(b + 9);
        chk("bounce_db_low", {31'd0, btn_db[BTN_L]}, 0);
        at_neg(b + 10);
        chk("bounce_db_high", {31'd0, btn_db[BTN_L]}, 1);
        post(c);
        btn_raw[BTN_L] = 1'b0;
        btn_raw[BTN_D] = 1'b1;
        at_neg(c + 6);
        chk("coin_tick", {31'd0, game_tick}, 1);
        at_neg(c + 7);
        chk("coin_dir", {28'd0, dir}, {28'd0, DIR_D});
        post(c + 40);
        btn_raw[BTN_D] = 1'b0;
        at_neg(c + 50);
        chk("release_dir", {28'd0, dir}, 0);

        // Invalid combinations: up+right, then right+centre
        i = c + 65;
        push_rise(i + 6, 5'b00010);
        hold_expect(DIR_U, i + 7, i + 10);
        push_rise(i + 16, 5'b01000);
        hold_expect(DIR_R, i + 27, i + 30);
        push_rise(i + 36, 5'b00001);
        post(i);
        btn_raw[BTN_U] = 1'b1;
        post(i + 10);
        btn_raw[BTN_R] = 1'b1;
        at_neg(i + 18);
        chk("combo_dir_zero", {28'd0, dir}, 0);
        post(i + 20);
        btn_raw[BTN_U] = 1'b0;
        at_neg(i + 27);
        chk("combo_dir_r", {28'd0, dir}, {28'd0, DIR_R});
        post(i + 30);
        btn_raw[BTN_C] = 1'b1;
        at_neg(i + 36);
        chk("centre_db", {27'd0, btn_db}, 32'b01001);
        at_neg(i + 38);
        chk("centre_dir", {28'd0, dir}, 0);
        post(i + 40);
        btn_raw = 5'd0;
        at_neg(i + 60);
        chk("final_db", {27'd0, btn_db}, 0);

        chk("stb_q_empty", stb_q.size(), 0);
        chk("rise_q_empty", rise_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
